// File: rtl/fixedpoint_multiplier_seq_pkg.sv
// Shared definitions for the sequential sign-magnitude fixed-point multiplier
// and the fixed-point blocks that reuse its saturation stage.
//   DEF_N / DEF_Q : default word width and fractional-bit count
//   mag_w()       : magnitude width for a given word width (N-1)
//   mag_max()     : saturation magnitude for a given word width (2^(N-1)-1)
//   fsm_state_t   : multiplier control states
package fixedpoint_multiplier_seq_pkg;

    localparam int DEF_N = 8;
    localparam int DEF_Q = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_t;

    function automatic int mag_w(input int n);
        return n - 1;
    endfunction

    function automatic longint mag_max(input int n);
        return (longint'(1) << (n - 1)) - 1;
    endfunction

endpackage

// File: rtl/fixedpoint_multiplier_seq_mag_saturate.sv
// fixedpoint_mag_saturate: turns a double-width unsigned magnitude product into
// an N-bit sign-magnitude word in the same Q format as the operands.
//   acc  : 2(N-1)-bit raw magnitude product (2Q fractional bits)
//   sign : sign of the result before zero canonicalisation
//   c    : sign-magnitude result; a zero magnitude always carries sign 0
//   ovf  : 1 when the shifted magnitude did not fit and was clamped
module fixedpoint_mag_saturate
    import fixedpoint_multiplier_seq_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int Q = DEF_Q
) (
    input  logic [2*(N-1)-1:0] acc,
    input  logic               sign,
    output logic [N-1:0]       c,
    output logic               ovf
);

    localparam int MAG_W = mag_w(N);
    localparam int ACC_W = 2 * MAG_W;

    logic [ACC_W-1:0] m;
    logic [MAG_W-1:0] mag;

    always_comb begin
        // Dropping the Q low bits truncates toward zero in magnitude.
        m   = acc >> Q;
        // Anything above the magnitude field means m exceeds MAG_MAX.
        ovf = |m[ACC_W-1:MAG_W];
        mag = ovf ? {MAG_W{1'b1}} : m[MAG_W-1:0];
        c   = {sign & (|mag), mag};
    end

endmodule

// File: rtl/fixedpoint_multiplier_seq.sv
// fixedpoint_multiplier_seq: shift-and-add multiplier for N-bit sign-magnitude
// fixed-point operands, one multiplier bit per clock (latency N from accept).
//   i_clk   : clock, rising edge
//   i_rst   : synchronous active-high reset, aborts any operation
//   i_start : request; accepted only while o_ready=1
//   i_a/i_b : operands, sampled on the accept edge
//   o_ready : idle and able to accept
//   o_valid : one-cycle pulse, new o_c/o_ovf
//   o_c     : saturated sign-magnitude product, held between results
//   o_ovf   : saturation flag for o_c, held between results
//
// state | meaning
// IDLE  | ready; start latches operands and clears acc/counter
// BUSY  | one multiplier bit per edge, LSB first, N-1 edges
// DONE  | register the saturated result and pulse o_valid
module fixedpoint_multiplier_seq
    import fixedpoint_multiplier_seq_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int Q = DEF_Q
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_ready,
    output logic         o_valid,
    output logic [N-1:0] o_c,
    output logic         o_ovf
);

    localparam int MAG_W = mag_w(N);
    localparam int ACC_W = 2 * MAG_W;
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAG_W - 1);

    fsm_state_t       state, state_nx;
    logic [MAG_W-1:0] a_mag, b_mag;
    logic             sign_q;
    logic [ACC_W-1:0] acc, addend;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     sat_c;
    logic             sat_ovf;

    fixedpoint_mag_saturate #(.N(N), .Q(Q)) u_sat (
        .acc  (acc),
        .sign (sign_q),
        .c    (sat_c),
        .ovf  (sat_ovf)
    );

    always_comb begin
        addend = {{MAG_W{1'b0}}, a_mag} << cnt;
    end

    always_comb begin
        state_nx = state;
        o_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_start) state_nx = ST_BUSY;
            end
            ST_BUSY: begin
                if (cnt == CNT_LAST) state_nx = ST_DONE;
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            a_mag   <= '0;
            b_mag   <= '0;
            sign_q  <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            o_valid <= 1'b0;
            o_c     <= '0;
            o_ovf   <= 1'b0;
        end else begin
            state   <= state_nx;
            o_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        a_mag  <= i_a[N-2:0];
                        b_mag  <= i_b[N-2:0];
                        sign_q <= i_a[N-1] ^ i_b[N-1];
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                ST_BUSY: begin
                    if (b_mag[cnt]) acc <= acc + addend;
                    cnt <= cnt + CNT_W'(1);
                end
                ST_DONE: begin
                    o_c     <= sat_c;
                    o_ovf   <= sat_ovf;
                    o_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fixedpoint_multiplier_seq.sv
module tb_fixedpoint_multiplier_seq;

    localparam int N = 8;
    localparam int Q = 4;
    localparam int MAG_MAX = (1 << (N - 1)) - 1;

    typedef struct packed {
        logic [N-1:0] c;
        logic         ovf;
    } res_t;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_start = 1'b0;
    logic [N-1:0] i_a = '0;
    logic [N-1:0] i_b = '0;
    logic         o_ready, o_valid, o_ovf;
    logic [N-1:0] o_c;

    int total = 0;
    int bad = 0;

    res_t exp_q[$];
    int   busy_left = 0;
    bit   exp_valid = 1'b0;
    bit   mon_en = 1'b0;
    logic [N-1:0] last_c = '0;
    logic         last_ovf = 1'b0;

    fixedpoint_multiplier_seq #(.N(N), .Q(Q)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_c     (o_c),
        .o_ovf   (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b);
        res_t r;
        int   p, m;
        logic [N-2:0] mag;
        p = int'(a[N-2:0]) * int'(b[N-2:0]);
        m = p >> Q;
        if (m > MAG_MAX) begin
            mag   = MAG_MAX[N-2:0];
            r.ovf = 1'b1;
        end else begin
            mag   = m[N-2:0];
            r.ovf = 1'b0;
        end
        r.c = {(a[N-1] ^ b[N-1]) && (mag != 0), mag};
        return r;
    endfunction

    // Reference timing model: accept when idle, result N edges later.
    always @(posedge i_clk) begin
        if (i_rst) begin
            busy_left = 0;
            exp_valid = 1'b0;
            exp_q.delete();
            last_c    = '0;
            last_ovf  = 1'b0;
        end else begin
            exp_valid = 1'b0;
            if (busy_left == 0) begin
                if (i_start) begin
                    exp_q.push_back(model(i_a, i_b));
                    busy_left = N;
                end
            end else begin
                busy_left--;
                if (busy_left == 0) exp_valid = 1'b1;
            end
        end
    end

    always @(negedge i_clk) begin
        if (mon_en) begin
            res_t r;
            chk("ready", 32'(o_ready), 32'(busy_left == 0));
            chk("valid", 32'(o_valid), 32'(exp_valid));
            if (exp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("queue_nonempty", 32'(0), 32'(1));
                end else begin
                    r = exp_q.pop_front();
                    chk("c", 32'(o_c), 32'(r.c));
                    chk("ovf", 32'(o_ovf), 32'(r.ovf));
                    last_c   = r.c;
                    last_ovf = r.ovf;
                end
            end else begin
                chk("hold_c", 32'(o_c), 32'(last_c));
                chk("hold_ovf", 32'(o_ovf), 32'(last_ovf));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b);
        while (busy_left != 0) tick(1);
        i_a = a;
        i_b = b;
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
    endtask

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
    } vec_t;

    vec_t dir_vecs[8] = '{
        '{8'h18, 8'h20}, '{8'h98, 8'h20}, '{8'h98, 8'hA0}, '{8'h80, 8'h25},
        '{8'h01, 8'h01}, '{8'h7F, 8'h20}, '{8'hFF, 8'h20}, '{8'h00, 8'h80}
    };

    initial begin
        // Reset held for two edges.
        tick(2);
        i_rst = 1'b0;
        chk("rst_ready", 32'(o_ready), 32'(1));
        chk("rst_valid", 32'(o_valid), 32'(0));
        chk("rst_c", 32'(o_c), 32'(0));
        chk("rst_ovf", 32'(o_ovf), 32'(0));
        mon_en = 1'b1;
        tick(20);

        // Directed products including sign, zero and saturation cases.
        foreach (dir_vecs[i]) do_op(dir_vecs[i].a, dir_vecs[i].b);
        tick(N + 2);

        // Start held high with operands alternating every cycle.
        i_start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            i_a = (k % 2 == 0) ? 8'h18 : 8'h9C;
            i_b = (k % 2 == 0) ? 8'h20 : 8'h33;
            tick(1);
        end
        i_start = 1'b0;
        tick(N + 2);

        // Second start mid-BUSY must be ignored.
        do_op(8'h23, 8'h45);
        tick(2);
        i_a = 8'h7F;
        i_b = 8'h7F;
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        tick(N + 2);

        // Reset at edge T0+3 aborts the operation.
        do_op(8'h18, 8'h20);
        tick(2);
        i_rst = 1'b1;
        tick(1);
        i_rst = 1'b0;
        chk("abort_c", 32'(o_c), 32'(0));
        chk("abort_ready", 32'(o_ready), 32'(1));
        do_op(8'h18, 8'h20);
        tick(N + 2);

        // Random operands.
        for (int k = 0; k < 20; k++) do_op(N'($urandom), N'($urandom));
        tick(N + 3);

        chk("drain", 32'(exp_q.size()), 32'(0));
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fixedpoint_multiplier_seq.md
Name: fixedpoint_multiplier_seq

Overview:
Sequential shift-and-add multiplier for N-bit sign-magnitude fixed-point operands. Bit N-1 is the sign; bits N-2:0 are the magnitude with Q fractional bits.
Sits directly upstream of the fixed-point adder and produces products in that adder's exact format, with +0 as the canonical zero, so the pair forms a multiply-accumulate datapath.
Trades latency for area: one magnitude bit per clock.

Parameters:
N, 8, total word width including sign bit; legal range N >= 3
Q, 4, number of fractional bits in the magnitude; legal range 0 <= Q <= N-2

Ports:
i_clk  input  1  single clock; all state updates on rising edge
i_rst  input  1  reset, synchronous, active-high
i_start  input  1  request a multiply; accepted only on an edge where o_ready=1
i_a  input  N  multiplicand, sign-magnitude; sampled on the accept edge only
i_b  input  N  multiplier, sign-magnitude; sampled on the accept edge only
o_ready  output  1  1 when IDLE and able to accept i_start
o_valid  output  1  one-cycle pulse: o_c/o_ovf hold a new result
o_c  output  N  product, sign-magnitude, same Q format as inputs
o_ovf  output  1  1 if the result saturated; qualified by o_valid, holds until next result

Behaviour:
- Reset (i_rst=1 at an edge), regardless of state:
  - state=IDLE; o_ready=1; o_valid=0; o_c=0; o_ovf=0.
  - Accumulator, counter and latched operands cleared.
  - An operation in flight is aborted with no o_valid.
- State IDLE:
  - o_ready=1.
  - On an edge with i_start=1 (call it T0): latch |a|=i_a[N-2:0], |b|=i_b[N-2:0], sign=i_a[N-1]^i_b[N-1].
  - Also at T0: clear the 2(N-1)-bit accumulator and the bit counter; go to BUSY.
- State BUSY:
  - o_ready=0; i_start is ignored (not queued).
  - Each edge processes one multiplier bit, LSB first: if bit i of |b|=1, acc += |a| << i; counter increments.
  - After N-1 BUSY edges (T0+1 .. T0+N-1), go to DONE.
- State DONE:
  - o_ready=0.
  - On edge T0+N: register o_c and o_ovf, set o_valid=1, go to IDLE.
- Output timing:
  - o_valid is high exactly for the cycle following edge T0+N, giving latency N clocks from accept.
  - o_ready is already 1 in the o_valid cycle, so back-to-back starts are allowed: a new start at edge T0+N+1 yields its o_valid after edge T0+2N+1.
  - o_c and o_ovf hold their last values while not in DONE.
- Arithmetic:
  - Compute m = acc >> Q. This truncates toward zero in magnitude; no rounding.
  - If m > 2^(N-1)-1: magnitude = 2^(N-1)-1 and o_ovf=1.
  - Otherwise: magnitude = m[N-2:0] and o_ovf=0.
- Sign:
  - o_c[N-1] = latched sign, except when the final magnitude = 0, in which case o_c[N-1]=0 (no -0 is ever emitted).
- Operand edge cases:
  - -0 inputs (magnitude 0, sign 1) are legal and yield +0.
  - Operands are not checked for any other encoding rule.
- Simultaneous events:
  - i_rst has priority over i_start and over any state transition.
  - i_start in the same cycle as o_valid is accepted normally.

Decomposition:
- Shared include fixed_point_defs.vh holds:
  - default N and Q;
  - magnitude width MAG_W = N-1;
  - saturation constant MAG_MAX = 2^(N-1)-1;
  - state encodings IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
- One natural combinational sub-module, fixedpoint_mag_saturate:
  - inputs: 2(N-1)-bit acc and the sign bit;
  - outputs: shifted, saturated N-bit sign-magnitude result and the ovf flag;
  - intended for reuse by later fixed-point blocks.
- FSM, counter and accumulator stay in the top module.

Test Plan:
- Reset then idle; i_rst held 2 cycles -> o_ready=1, o_valid=0, o_c=0x00, o_ovf=0; no o_valid over 20 idle cycles.
- Basic product: i_a=0x18 (1.5), i_b=0x20 (2.0), start at T0 -> o_valid exactly in cycle after T0+8, o_c=0x30 (3.0), o_ovf=0; o_ready=0 during T0+1..T0+8.
- Signs and zero:
  - 0x98 x 0x20 -> 0xB0.
  - 0x98 x 0xA0 -> 0x30.
  - 0x80 x 0x25 -> 0x00 (sign 0).
  - 0x01 x 0x01 (truncates to 0) -> 0x00, o_ovf=0.
- Saturation:
  - 0x7F x 0x20 (raw 4064>>4=254) -> o_c=0x7F, o_ovf=1.
  - 0xFF x 0x20 -> o_c=0xFF, o_ovf=1.
- Handshake:
  - i_start held high continuously with alternating operands -> one result every 9 cycles, each matching its own operands.
  - A second start pulse mid-BUSY -> ignored; exactly one o_valid.
- Reset mid-operation: start 0x18 x 0x20, assert i_rst at edge T0+3 -> no o_valid ever for that op; o_c=0x00 and o_ready=1 in the following cycle; a new start then completes normally.
